// File: rtl/block_encode_coeffs_if.sv
// block_encode_coeffs_if
//
// Bundles the symbol handshake, the code-ROM port and the serial bit
// stream of the coefficient VLC encoder.
//
//   slave  : the encoder's view (symbols and ROM data in; bits, ROM
//            request, error and bit count out)
//   master : the environment's view (scanner, ROM and bitstream packer)
//
// Symbol side : Sym_Valid_I / Sym_Ready_O, Run_I[5:0], Level_I[11:0],
//               EOB_I, First_Coeff_I, Table_Sel_I
// ROM side    : Code_Table_En_O, Code_Table_Addr_O[9:0],
//               Code_Table_Data_I[20:0] = {length[4:0], code[15:0]}
// Bit side    : Bit_O, Bit_Valid_O / Bit_Ready_I
// Status      : Err_O, Bit_Count_O[15:0]

interface block_encode_coeffs_if;
    logic        Sym_Valid_I;
    logic        Sym_Ready_O;
    logic [5:0]  Run_I;
    logic [11:0] Level_I;
    logic        EOB_I;
    logic        First_Coeff_I;
    logic        Table_Sel_I;
    logic        Code_Table_En_O;
    logic [9:0]  Code_Table_Addr_O;
    logic [20:0] Code_Table_Data_I;
    logic        Bit_O;
    logic        Bit_Valid_O;
    logic        Bit_Ready_I;
    logic        Err_O;
    logic [15:0] Bit_Count_O;

    modport slave (
        input  Sym_Valid_I, Run_I, Level_I, EOB_I, First_Coeff_I, Table_Sel_I,
        input  Code_Table_Data_I, Bit_Ready_I,
        output Sym_Ready_O, Code_Table_En_O, Code_Table_Addr_O,
        output Bit_O, Bit_Valid_O, Err_O, Bit_Count_O
    );

    modport master (
        output Sym_Valid_I, Run_I, Level_I, EOB_I, First_Coeff_I, Table_Sel_I,
        output Code_Table_Data_I, Bit_Ready_I,
        input  Sym_Ready_O, Code_Table_En_O, Code_Table_Addr_O,
        input  Bit_O, Bit_Valid_O, Err_O, Bit_Count_O
    );
endinterface

// File: rtl/block_encode_coeffs.sv
// block_encode_coeffs
//
// Bit-serial variable-length encoder for DCT (run, level) symbols using
// the MPEG-2 B.14 / B.15 coefficient tables. One symbol is taken per
// handshake; table codes come from an external synchronous ROM with a
// read latency of one cycle. Each symbol is emitted MSB-first as one of:
//   - end-of-block code (EOB_B14 or EOB_B15)
//   - first-coefficient short code {1, sign}
//   - escape: {000001, run[5:0], level[11:0]}
//   - table code {code[L-1:0], sign}, or escape when the ROM has no entry
// Illegal symbols (level 0 or -2048) are dropped with a one-cycle Err_O.
//
// Ports:
//   clock   system clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     block_encode_coeffs_if.slave (symbol, ROM and bit streams)
//
// Optional feature: define BLK_ENC_BIT_COUNT_EN to build a saturating
// per-block bit counter on Bit_Count_O; otherwise it is tied to 0.
//
// States:
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_IDLE   | no codeword pending, ready for a symbol
//   ST_LOOKUP | ROM data for the registered symbol is valid this cycle
//   ST_SHIFT  | shifting out SR[23], CNT bits remaining (CNT >= 1)

module block_encode_coeffs #(
    parameter int         ROM_LATENCY = 1,
    parameter logic [1:0] EOB_B14     = 2'b10,
    parameter logic [3:0] EOB_B15     = 4'b0110
) (
    input  logic                        clock,
    input  logic                        resetn,
    block_encode_coeffs_if.slave        bus
);

    if (ROM_LATENCY != 1) begin : g_rom_latency_check
        $error("block_encode_coeffs supports ROM_LATENCY == 1 only");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_SHIFT
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] sr_q, sr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [5:0]  run_q, run_d;
    logic [11:0] level_q, level_d;
    logic        err_q, err_d;

    // Input classification
    logic        level_neg;
    logic [11:0] level_mag;
    logic [3:0]  level_mag_m1;
    logic        sym_illegal;
    logic        sym_first;
    logic        sym_escape;
    logic        sym_table;

    // Handshake / datapath controls
    logic        last_bit;
    logic        sym_ready;
    logic        sym_accept;
    logic        bit_take;
    logic [4:0]  rom_len;
    logic [23:0] rom_word;

    function automatic logic [23:0] escape_word(input logic [5:0]  run,
                                                input logic [11:0] level);
        escape_word = {6'b000001, run, level};
    endfunction

    always_comb begin
        level_neg    = bus.Level_I[11];
        level_mag    = level_neg ? (12'd0 - bus.Level_I) : bus.Level_I;
        level_mag_m1 = level_mag[3:0] - 4'd1;

        // -2048 has no positive counterpart in 12 bits, so it is rejected.
        sym_illegal = !bus.EOB_I &&
                      ((bus.Level_I == 12'h000) || (bus.Level_I == 12'h800));
        sym_first   = !bus.EOB_I && !sym_illegal && bus.First_Coeff_I &&
                      !bus.Table_Sel_I && (bus.Run_I == 6'd0) &&
                      (level_mag == 12'd1);
        sym_escape  = !bus.EOB_I && !sym_illegal && !sym_first &&
                      (bus.Run_I[5] || (level_mag > 12'd16));
        sym_table   = !bus.EOB_I && !sym_illegal && !sym_first && !sym_escape;
    end

    always_comb begin
        bit_take   = (state_q == ST_SHIFT) && bus.Bit_Ready_I;
        last_bit   = bit_take && (cnt_q == 5'd1);
        // Accepting on the final shift cycle lets direct-load codewords
        // stream back to back without an idle bubble.
        sym_ready  = (state_q == ST_IDLE) || last_bit;
        sym_accept = sym_ready && bus.Sym_Valid_I;

        // Left-align {code[L-1:0], sign}; code bits above L fall off the top.
        rom_len  = bus.Code_Table_Data_I[20:16];
        rom_word = {7'd0, bus.Code_Table_Data_I[15:0], level_q[11]} << (5'd23 - rom_len);
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        level_d = level_q;
        err_d   = 1'b0;

        case (state_q)
            ST_LOOKUP: begin
                if (rom_len == 5'd0) begin
                    sr_d  = escape_word(run_q, level_q);
                    cnt_d = 5'd24;
                end else begin
                    sr_d  = rom_word;
                    cnt_d = rom_len + 5'd1;
                end
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_take) begin
                    sr_d  = sr_q << 1;
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: ;
        endcase

        // A new symbol overrides the end-of-codeword transition above.
        if (sym_accept) begin
            if (sym_illegal) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end else if (bus.EOB_I) begin
                sr_d    = bus.Table_Sel_I ? {EOB_B15, 20'd0} : {EOB_B14, 22'd0};
                cnt_d   = bus.Table_Sel_I ? 5'd4 : 5'd2;
                state_d = ST_SHIFT;
            end else if (sym_first) begin
                sr_d    = {1'b1, level_neg, 22'd0};
                cnt_d   = 5'd2;
                state_d = ST_SHIFT;
            end else if (sym_escape) begin
                sr_d    = escape_word(bus.Run_I, bus.Level_I);
                cnt_d   = 5'd24;
                state_d = ST_SHIFT;
            end else begin
                run_d   = bus.Run_I;
                level_d = bus.Level_I;
                state_d = ST_LOOKUP;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            sr_q    <= 24'd0;
            cnt_q   <= 5'd0;
            run_q   <= 6'd0;
            level_q <= 12'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            level_q <= level_d;
            err_q   <= err_d;
        end
    end

    assign bus.Sym_Ready_O       = sym_ready;
    assign bus.Code_Table_En_O   = sym_accept && sym_table;
    assign bus.Code_Table_Addr_O = {bus.Table_Sel_I, bus.Run_I[4:0], level_mag_m1};
    assign bus.Bit_O             = sr_q[23];
    assign bus.Bit_Valid_O       = (state_q == ST_SHIFT);
    assign bus.Err_O             = err_q;

`ifdef BLK_ENC_BIT_COUNT_EN
    // eob_q marks that the codeword being shifted is an end-of-block, so
    // the count restarts once its last bit has gone out.
    logic        eob_q, eob_d;
    logic [15:0] bit_count_q, bit_count_d;

    always_comb begin
        eob_d       = eob_q;
        bit_count_d = bit_count_q;
        if (state_q == ST_LOOKUP) begin
            eob_d = 1'b0;
        end
        if (sym_accept) begin
            eob_d = bus.EOB_I;
        end
        if (bit_take) begin
            if (eob_q && (cnt_q == 5'd1)) begin
                bit_count_d = 16'd0;
            end else if (bit_count_q != 16'hFFFF) begin
                bit_count_d = bit_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            eob_q       <= 1'b0;
            bit_count_q <= 16'd0;
        end else begin
            eob_q       <= eob_d;
            bit_count_q <= bit_count_d;
        end
    end

    assign bus.Bit_Count_O = bit_count_q;
`else
    assign bus.Bit_Count_O = 16'd0;
`endif

endmodule

// File: tb/tb_block_encode_coeffs.sv
// Testbench for block_encode_coeffs: behavioural reference (expected bit
// queue built from the coding rules), per-cycle compare process, directed
// literal cases and a randomized symbol/back-pressure run.
module tb_block_encode_coeffs;

    logic clock = 1'b0;
    logic resetn = 1'b0;

    block_encode_coeffs_if bus();

    block_encode_coeffs dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous code ROM, one-cycle latency
    logic [20:0] rom [0:1023];
    logic [20:0] rom_dout = 21'd0;
    always @(posedge clock) if (bus.Code_Table_En_O) rom_dout <= rom[bus.Code_Table_Addr_O];
    assign bus.Code_Table_Data_I = rom_dout;

    typedef struct packed {
        logic b;
        logic eob_last;
    } ent_t;

    ent_t        expq[$];
    bit          err_pend = 0;
    bit          lookup_pend = 0;
    logic [15:0] mcnt = 16'd0;

    bit          cap[$];
    int          cap_cyc[$];
    logic [15:0] cap_bc[$];
    int          last_acc;
    logic        last_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_bits(input logic [23:0] v, input int n, input bit eob);
        for (int i = n - 1; i >= 0; i--) begin
            ent_t e;
            e.b = v[i];
            e.eob_last = eob && (i == 0);
            expq.push_back(e);
        end
    endtask

    // Reference: derive the full codeword of an accepted symbol
    task automatic model_accept();
        int lv, mag, a, len;
        logic neg;
        logic [20:0] d;
        logic exp_en;
        lv  = int'($signed(bus.Level_I));
        mag = (lv < 0) ? -lv : lv;
        neg = (lv < 0);
        exp_en = 1'b0;
        if (!bus.EOB_I && (lv == 0 || lv == -2048)) begin
            err_pend = 1;
        end else if (bus.EOB_I) begin
            if (bus.Table_Sel_I) push_bits(24'b0110, 4, 1);
            else                 push_bits(24'b10, 2, 1);
        end else if (bus.First_Coeff_I && !bus.Table_Sel_I && bus.Run_I == 0 && mag == 1) begin
            push_bits({22'd0, 1'b1, neg}, 2, 0);
        end else if (bus.Run_I > 31 || mag > 16) begin
            push_bits({6'b000001, bus.Run_I, bus.Level_I}, 24, 0);
        end else begin
            exp_en = 1'b1;
            a = int'(bus.Table_Sel_I) * 512 + (int'(bus.Run_I) % 32) * 16 + (mag - 1);
            chk("rom_addr", 32'(bus.Code_Table_Addr_O), 32'(a));
            d   = rom[a];
            len = int'(d[20:16]);
            if (len == 0) push_bits({6'b000001, bus.Run_I, bus.Level_I}, 24, 0);
            else          push_bits({7'd0, d[15:0], neg}, len + 1, 0);
            lookup_pend = 1;
        end
        chk("rom_en_accept", 32'(bus.Code_Table_En_O), 32'(exp_en));
    endtask

    always @(negedge clock) begin : compare
        int qs;
        bit lk;
        ent_t e;
        if (!resetn) begin
            expq.delete();
            err_pend = 0;
            lookup_pend = 0;
            mcnt = 16'd0;
        end else begin
            qs = expq.size();
            lk = lookup_pend;
            lookup_pend = 0;
            chk("sym_ready", 32'(bus.Sym_Ready_O), 32'((qs == 0) || (qs == 1 && bus.Bit_Ready_I)));
            chk("bit_valid", 32'(bus.Bit_Valid_O), 32'((qs > 0) && !lk));
            chk("err_o", 32'(bus.Err_O), 32'(err_pend));
            err_pend = 0;
`ifdef BLK_ENC_BIT_COUNT_EN
            chk("bit_count", 32'(bus.Bit_Count_O), 32'(mcnt));
`endif
            if (bus.Bit_Valid_O && bus.Bit_Ready_I) begin
                cap.push_back(bus.Bit_O);
                cap_cyc.push_back(cyc);
                cap_bc.push_back(bus.Bit_Count_O);
                if (qs == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bit_extra: got bit %0b expected no bit (cycle %0d)", bus.Bit_O, cyc);
                end else begin
                    e = expq.pop_front();
                    chk("bit_o", 32'(bus.Bit_O), 32'(e.b));
                    if (e.eob_last) mcnt = 16'd0;
                    else if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
                end
            end
            if (bus.Sym_Valid_I && bus.Sym_Ready_O) model_accept();
            else chk("rom_en_idle", 32'(bus.Code_Table_En_O), 32'd0);
        end
    end

    function automatic logic [31:0] cap_vec();
        logic [31:0] v;
        v = 32'd0;
        foreach (cap[i]) v = {v[30:0], cap[i]};
        return v;
    endfunction

    task automatic cap_clear();
        cap.delete();
        cap_cyc.delete();
        cap_bc.delete();
    endtask

    // Entered and left at posedge+1; Sym_Valid_I is low on return.
    task automatic send(input bit eob, input bit first, input bit tsel,
                        input logic [5:0] run, input logic [11:0] level);
        bit acc;
        acc = 0;
        bus.EOB_I = eob;
        bus.First_Coeff_I = first;
        bus.Table_Sel_I = tsel;
        bus.Run_I = run;
        bus.Level_I = level;
        bus.Sym_Valid_I = 1'b1;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clock);
            if (bus.Sym_Ready_O) begin
                acc = 1;
                last_acc = cyc;
                last_en = bus.Code_Table_En_O;
            end
            @(posedge clock); #1;
        end
        bus.Sym_Valid_I = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: got no accept expected accept within 300 cycles");
        end
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clock);
            if (expq.size() == 0 && bus.Sym_Ready_O && !bus.Bit_Valid_O) done = 1;
            @(posedge clock); #1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: got %0d bits pending expected 0", expq.size());
        end
    endtask

    task automatic rand_sym();
        int k, mag;
        bit neg;
        bus.EOB_I = ($urandom_range(0, 99) < 10);
        bus.Table_Sel_I = 1'($urandom_range(0, 1));
        bus.First_Coeff_I = ($urandom_range(0, 3) == 0);
        bus.Run_I = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 31));
        neg = 1'($urandom_range(0, 1));
        k = $urandom_range(0, 99);
        if (k < 5) begin
            bus.Level_I = (k < 3) ? 12'h000 : 12'h800;
        end else begin
            if (k < 25) begin
                bus.Run_I = 6'd0;
                mag = 1;
            end else if (k < 80) mag = $urandom_range(1, 16);
            else mag = $urandom_range(17, 2047);
            bus.Level_I = neg ? 12'(-mag) : 12'(mag);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int errc;
        logic held;

        for (int i = 0; i < 1024; i++) begin
            int len;
            len = ($urandom_range(0, 9) < 2) ? 0 : $urandom_range(1, 16);
            rom[i] = {5'(len), 16'($urandom)};
        end
        rom[0] = 21'h020003;
        rom[10'h034] = 21'h000000;

        bus.Sym_Valid_I = 1'b0;
        bus.Run_I = 6'd0;
        bus.Level_I = 12'd0;
        bus.EOB_I = 1'b0;
        bus.First_Coeff_I = 1'b0;
        bus.Table_Sel_I = 1'b0;
        bus.Bit_Ready_I = 1'b1;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_sym_ready", 32'(bus.Sym_Ready_O), 32'd1);
        chk("rst_bit_valid", 32'(bus.Bit_Valid_O), 32'd0);
        chk("rst_bit_o", 32'(bus.Bit_O), 32'd0);
        chk("rst_err", 32'(bus.Err_O), 32'd0);
        chk("rst_rom_en", 32'(bus.Code_Table_En_O), 32'd0);
        chk("rst_bit_count", 32'(bus.Bit_Count_O), 32'd0);
        resetn = 1'b1;
        @(posedge clock); #1;

        // Table path: B.14, run 0, level +1, ROM gives length 2 code 11
        cap_clear();
        send(0, 0, 0, 6'd0, 12'd1);
        chk("t1_rom_en", 32'(last_en), 32'd1);
        drain();
        chk("t1_len", 32'(cap.size()), 32'd3);
        chk("t1_bits", cap_vec(), 32'b110);
        if (cap.size() > 0) chk("t1_latency", 32'(cap_cyc[0] - last_acc), 32'd2);

        // First-coefficient short code, negative
        cap_clear();
        send(0, 1, 0, 6'd0, 12'hFFF);
        chk("t2_rom_en", 32'(last_en), 32'd0);
        drain();
        chk("t2_len", 32'(cap.size()), 32'd2);
        chk("t2_bits", cap_vec(), 32'b11);
        if (cap.size() > 0) chk("t2_latency", 32'(cap_cyc[0] - last_acc), 32'd1);

        // ROM miss falls back to escape
        cap_clear();
        send(0, 0, 0, 6'd3, 12'hFFB);
        chk("t3_rom_en", 32'(last_en), 32'd1);
        drain();
        chk("t3_len", 32'(cap.size()), 32'd24);
        chk("t3_bits", cap_vec(), 32'b000001_000011_111111111011);

        // Long run escapes directly
        cap_clear();
        send(0, 0, 0, 6'd40, 12'hFFB);
        chk("t3b_rom_en", 32'(last_en), 32'd0);
        drain();
        chk("t3b_len", 32'(cap.size()), 32'd24);
        chk("t3b_bits", cap_vec(), 32'b000001_101000_111111111011);
        if (cap.size() > 0) chk("t3b_latency", 32'(cap_cyc[0] - last_acc), 32'd1);

        // B.15 EOB then escape back to back
        cap_clear();
        send(1, 0, 1, 6'd0, 12'd0);
        send(0, 0, 0, 6'd40, 12'd100);
        drain();
        chk("t4_len", 32'(cap.size()), 32'd28);
        chk("t4_bits", cap_vec(), 32'b0110_000001_101000_000001100100);
        if (cap.size() >= 5) chk("t4_no_gap", 32'(cap_cyc[4] - cap_cyc[3]), 32'd1);
`ifdef BLK_ENC_BIT_COUNT_EN
        if (cap.size() >= 6) begin
            chk("t4_count_cleared", 32'(cap_bc[4]), 32'd0);
            chk("t4_count_restart", 32'(cap_bc[5]), 32'd1);
        end
`endif

        // Back-pressure mid-codeword
        cap_clear();
        send(0, 0, 0, 6'd33, 12'd7);
        repeat (3) begin
            @(posedge clock); #1;
        end
        bus.Bit_Ready_I = 1'b0;
        held = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (i == 0) held = bus.Bit_O;
            else chk("t5_bit_hold", 32'(bus.Bit_O), 32'(held));
            chk("t5_valid_hold", 32'(bus.Bit_Valid_O), 32'd1);
            chk("t5_ready_low", 32'(bus.Sym_Ready_O), 32'd0);
            @(posedge clock); #1;
        end
        bus.Bit_Ready_I = 1'b1;
        drain();
        chk("t5_len", 32'(cap.size()), 32'd24);
        chk("t5_bits", cap_vec(), 32'b000001_100001_000000000111);

        // Illegal levels
        for (int t = 0; t < 2; t++) begin
            send(0, 0, 0, 6'd5, (t == 0) ? 12'h000 : 12'h800);
            errc = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clock);
                errc += int'(bus.Err_O);
                chk("t6_no_bits", 32'(bus.Bit_Valid_O), 32'd0);
                chk("t6_ready", 32'(bus.Sym_Ready_O), 32'd1);
                @(posedge clock); #1;
            end
            chk("t6_err_pulse_len", 32'(errc), 32'd1);
        end

        // Asynchronous reset during SHIFT
        send(0, 0, 0, 6'd50, 12'h123);
        repeat (3) begin
            @(posedge clock); #1;
        end
        #2 resetn = 1'b0;
        #1;
        chk("t7_valid", 32'(bus.Bit_Valid_O), 32'd0);
        chk("t7_ready", 32'(bus.Sym_Ready_O), 32'd1);
        chk("t7_bit_o", 32'(bus.Bit_O), 32'd0);
        chk("t7_err", 32'(bus.Err_O), 32'd0);
        chk("t7_bit_count", 32'(bus.Bit_Count_O), 32'd0);
        @(posedge clock); #1;
        resetn = 1'b1;
        @(posedge clock); #1;

        // Randomized symbols with random back-pressure
        for (int c = 0; c < 4000; c++) begin
            bus.Bit_Ready_I = ($urandom_range(0, 3) != 0);
            bus.Sym_Valid_I = ($urandom_range(0, 9) < 7);
            rand_sym();
            @(posedge clock); #1;
        end
        bus.Sym_Valid_I = 1'b0;
        bus.Bit_Ready_I = 1'b1;
        drain();
        chk("final_pending", 32'(expq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/block_encode_coeffs.md
Name: block_encode_coeffs

Overview:
Bit-serial variable-length encoder for DCT coefficient (run, level) symbols, using MPEG-2 tables B.14/B.15. It accepts one symbol per handshake and looks up the VLC in an external synchronous code ROM. It emits the codeword MSB-first, followed by the sign bit, or the escape sequence or end-of-block code as required. It sits between the quantiser/zig-zag scanner and the bitstream packer, and is the encode-side counterpart of the coefficient VLC decoder.

Parameters:
ROM_LATENCY, 1, code ROM read latency in cycles. Only 1 is supported.
EOB_B14, 2'b10, end-of-block code for table B.14.
EOB_B15, 4'b0110, end-of-block code for table B.15.

Ports:
clock  in  1  system clock, rising edge.
resetn  in  1  reset; asynchronous, active-low.
Sym_Valid_I  in  1  symbol present.
Sym_Ready_O  out  1  symbol accepted when Sym_Valid_I and Sym_Ready_O are both high ("accept").
Run_I  in  6  zero run, 0..63.
Level_I  in  12  signed level. Legal range: -2047..-1 and 1..2047.
EOB_I  in  1  symbol is end-of-block; Run_I and Level_I are ignored.
First_Coeff_I  in  1  first coefficient of a non-intra block.
Table_Sel_I  in  1  0 = B.14, 1 = B.15. Sampled at accept.
Code_Table_En_O  out  1  ROM read enable.
Code_Table_Addr_O  out  10  ROM address: {Table_Sel_I, Run_I[4:0], |Level_I|-1 [3:0]}.
Code_Table_Data_I  in  21  [20:16] code length L (0 = no entry), [15:0] code, right-aligned.
Bit_O  out  1  serial bit.
Bit_Valid_O  out  1  Bit_O is valid.
Bit_Ready_I  in  1  sink consumes Bit_O when Bit_Valid_O and Bit_Ready_I are both high.
Err_O  out  1  one-cycle pulse when an illegal symbol is dropped.
Bit_Count_O  out  16  bits emitted in the current block (optional feature).

Behaviour:
- Reset values: Sym_Ready_O=1, Bit_Valid_O=0, Bit_O=0, Err_O=0, Code_Table_En_O=0, Bit_Count_O=0, state=IDLE.
- Internal datapath: 24-bit shift register SR, loaded left-aligned; 5-bit remaining-bit count CNT. Bit_O=SR[23]. Each consumed bit shifts SR left by 1 and decrements CNT.
- States: IDLE, LOOKUP, SHIFT.
- IDLE, on accept, classify the symbol:
  - Illegal (not EOB, and Level_I is 0 or -2048): pulse Err_O for one cycle, emit no bits, stay in IDLE.
  - EOB: load EOB_B14 (CNT=2) or EOB_B15 (CNT=4) → SHIFT.
  - First_Coeff_I=1, Table_Sel_I=0, Run_I=0, |Level_I|=1: load {1, sign} (CNT=2) → SHIFT.
  - Run_I>31 or |Level_I|>16: escape. Load {000001, Run_I, Level_I two's complement} (CNT=24) → SHIFT.
  - Otherwise: assert Code_Table_En_O in the accept cycle (combinational from the inputs) → LOOKUP.
- LOOKUP, one cycle; ROM data is valid in this cycle:
  - If L=0: load the escape sequence from the registered symbol.
  - Else: load {code[L-1:0], sign} with CNT=L+1; sign is 1 when the level is negative.
  - → SHIFT.
- SHIFT: Bit_Valid_O=1. On consume with CNT=1 → IDLE. CNT never reaches 0 while in SHIFT.
- Sym_Ready_O = (state==IDLE) OR (state==SHIFT and CNT==1 and Bit_Ready_I). A symbol accepted in that last SHIFT cycle is classified exactly as in IDLE, so direct-load symbols stream with no gap.
- Latency from accept to first Bit_Valid_O: 1 cycle for the direct-load paths (EOB, first-coeff, escape); 2 cycles for the table path.
- Back-pressure: while Bit_Ready_I=0, Bit_O, Bit_Valid_O and CNT hold.
- Sym_Ready_O is low in LOOKUP and low in SHIFT with CNT>1.
- An asynchronous reset mid-symbol discards the partial codeword; all outputs return to reset values immediately.

Optional Feature:
BLK_ENC_BIT_COUNT_EN.
- Defined: Bit_Count_O increments on each consumed bit, saturating at 16'hFFFF. It clears to 0 on the cycle after the last EOB bit is consumed.
- Undefined: Bit_Count_O is tied to 0 and no counter logic is built.

Test Plan:
- B.14, not first, Run=0, Level=+1; ROM addr 0x000 returns 0x02_0003 → Code_Table_En_O=1 at accept; bits 1,1,0; first Bit_Valid_O at accept+2.
- First_Coeff_I=1, Table_Sel_I=0, Run=0, Level=-1 → no ROM read; bits 1,1 starting at accept+1.
- Run=3, Level=-5, with ROM returning L=0 → 24 bits: 000001 000011 111111111011. Repeat with Run=40 (no ROM read) → 000001 101000 111111111011.
- EOB_I=1 with Table_Sel_I=1 → 0110. Then an escape symbol issued back-to-back → its first bit follows the last EOB bit with no gap. With BLK_ENC_BIT_COUNT_EN defined, Bit_Count_O reads 0 the cycle after the EOB completes.
- Bit_Ready_I held low for 5 cycles mid-codeword → Bit_O stable, no bit lost or duplicated; Sym_Ready_O stays 0.
- Level_I=0 → Err_O pulses for exactly 1 cycle, Bit_Valid_O stays 0, Sym_Ready_O stays 1. Asserting resetn low during a SHIFT → Bit_Valid_O=0 immediately.
